// File: rtl/microwave_ctrl_pwr.sv
// Microwave controller core: keypad time entry, BCD countdown, duty-cycled
// magnetron enable with selectable power level, and an end-of-cook beep window.
module microwave_ctrl_pwr #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MIN_DIGITS    = 1,
    parameter int POWER_STEPS   = 10,
    parameter int BEEP_SECS     = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [9:0]                         keypad,
    input  logic                               start,
    input  logic                               stop,
    input  logic                               clear,
    input  logic                               power_key,
    input  logic                               door_closed,
    output logic [3:0]                         sec_ones,
    output logic [3:0]                         sec_tens,
    output logic [4*MIN_DIGITS-1:0]            mins,
    output logic [$clog2(POWER_STEPS+1)-1:0]   power,
    output logic                               mag_on,
    output logic                               done,
    output logic [1:0]                         state
);
    localparam int PW = $clog2(POWER_STEPS + 1);
    localparam int CW = $clog2(TICKS_PER_SEC);
    localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
    localparam int MW = 4 * MIN_DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e        state_q;
    logic [3:0]    sec_ones_q, sec_tens_q;
    logic [MW-1:0] mins_q;
    logic [PW-1:0] power_q, win_q;
    logic [CW-1:0] presc_q;
    logic [BW-1:0] beep_q;
    logic          done_q;
    logic [9:0]    key_prev_q;
    logic          pwr_prev_q;

    logic          key_ok, pwr_edge, tick, time_zero, dec_zero, borrow;
    logic [3:0]    key_idx, dec_ones, dec_tens;
    logic [MW-1:0] dec_mins, shift_mins;
    logic [PW-1:0] power_inc, win_next;

    always_comb begin
        key_idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) key_idx = 4'(i);
        end
        key_ok     = (state_q == IDLE) && $onehot(keypad) && (key_prev_q == 10'd0);
        pwr_edge   = power_key && !pwr_prev_q;
        power_inc  = (power_q == PW'(POWER_STEPS)) ? PW'(1) : power_q + PW'(1);
        win_next   = (win_q == PW'(POWER_STEPS - 1)) ? '0 : win_q + PW'(1);
        tick       = (presc_q == CW'(TICKS_PER_SEC - 1));
        time_zero  = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (mins_q == '0);
        shift_mins = mins_q << 4;
        shift_mins[3:0] = sec_tens_q;

        // BCD countdown; a minutes borrow turns lower zero digits into 9s
        dec_ones = sec_ones_q;
        dec_tens = sec_tens_q;
        dec_mins = mins_q;
        borrow   = 1'b0;
        if (sec_ones_q != 4'd0) begin
            dec_ones = sec_ones_q - 4'd1;
        end else if (sec_tens_q != 4'd0) begin
            dec_tens = sec_tens_q - 4'd1;
            dec_ones = 4'd9;
        end else begin
            dec_ones = 4'd9;
            dec_tens = 4'd5;
            borrow   = 1'b1;
            for (int i = 0; i < MIN_DIGITS; i++) begin
                if (borrow) begin
                    if (mins_q[4*i +: 4] == 4'd0) begin
                        dec_mins[4*i +: 4] = 4'd9;
                    end else begin
                        dec_mins[4*i +: 4] = mins_q[4*i +: 4] - 4'd1;
                        borrow = 1'b0;
                    end
                end
            end
        end
        dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0) && (dec_mins == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            mins_q     <= '0;
            power_q    <= PW'(POWER_STEPS);
            win_q      <= '0;
            presc_q    <= '0;
            beep_q     <= '0;
            done_q     <= 1'b0;
            key_prev_q <= 10'd0;
            pwr_prev_q <= 1'b0;
        end else begin
            key_prev_q <= keypad;
            pwr_prev_q <= power_key;
            if (clear) begin
                state_q    <= IDLE;
                sec_ones_q <= 4'd0;
                sec_tens_q <= 4'd0;
                mins_q     <= '0;
                power_q    <= PW'(POWER_STEPS);
                done_q     <= 1'b0;
            end else if (stop) begin
                if (state_q == COOK) begin
                    state_q <= PAUSE;
                end else begin
                    if (state_q != DONE) begin
                        sec_ones_q <= 4'd0;
                        sec_tens_q <= 4'd0;
                        mins_q     <= '0;
                    end
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && door_closed && !time_zero) begin
                            state_q <= COOK;
                            presc_q <= '0;
                            win_q   <= '0;
                        end else begin
                            if (key_ok) begin
                                mins_q     <= shift_mins;
                                sec_tens_q <= sec_ones_q;
                                sec_ones_q <= key_idx;
                            end
                            if (pwr_edge) power_q <= power_inc;
                        end
                    end
                    PAUSE: begin
                        if (start && door_closed) begin
                            state_q <= COOK;
                            presc_q <= '0;
                        end else if (pwr_edge) begin
                            power_q <= power_inc;
                        end
                    end
                    COOK: begin
                        // An open door wins over a coincident tick, which is lost
                        if (!door_closed) begin
                            state_q <= PAUSE;
                        end else if (tick) begin
                            presc_q    <= '0;
                            win_q      <= win_next;
                            sec_ones_q <= dec_ones;
                            sec_tens_q <= dec_tens;
                            mins_q     <= dec_mins;
                            if (dec_zero) begin
                                state_q <= DONE;
                                beep_q  <= '0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            presc_q <= presc_q + CW'(1);
                        end
                    end
                    DONE: begin
                        if (!door_closed || start) begin
                            state_q <= IDLE;
                            done_q  <= 1'b0;
                        end else if (tick) begin
                            presc_q <= '0;
                            if (beep_q == BW'(BEEP_SECS - 1)) begin
                                state_q <= IDLE;
                                done_q  <= 1'b0;
                            end else begin
                                beep_q <= beep_q + BW'(1);
                            end
                        end else begin
                            presc_q <= presc_q + CW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Combinational so the magnetron drops in the very cycle the door opens
    assign mag_on   = (state_q == COOK) && door_closed && (win_q < power_q);
    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign mins     = mins_q;
    assign power    = power_q;
    assign done     = done_q;
    assign state    = state_q;
endmodule

// File: tb/tb_microwave_ctrl_pwr.sv
// Directed vector table for microwave_ctrl_pwr (TICKS_PER_SEC=4, POWER_STEPS=4,
// BEEP_SECS=2, MIN_DIGITS=1) plus a hand-written done-window sequence.
module tb_microwave_ctrl_pwr;
  localparam int TPS  = 4;
  localparam int MIND = 1;
  localparam int PS   = 4;
  localparam int BEEP = 2;
  localparam int PW   = $clog2(PS + 1);

  logic          clk = 1'b0;
  logic          rst, start, stop, clear, power_key, door_closed;
  logic [9:0]    keypad;
  logic [3:0]    sec_ones, sec_tens;
  logic [4*MIND-1:0] mins;
  logic [PW-1:0] power;
  logic          mag_on, done;
  logic [1:0]    state;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  microwave_ctrl_pwr #(
    .TICKS_PER_SEC(TPS), .MIN_DIGITS(MIND), .POWER_STEPS(PS), .BEEP_SECS(BEEP)
  ) dut (
    .clk(clk), .rst(rst), .keypad(keypad), .start(start), .stop(stop),
    .clear(clear), .power_key(power_key), .door_closed(door_closed),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins), .power(power),
    .mag_on(mag_on), .done(done), .state(state)
  );

  typedef struct packed {
    logic          r;
    logic [9:0]    kp;
    logic          st, sp, cl, pk, dr;
    int            cycles;
    logic [3:0]    e_ones, e_tens, e_mins;
    logic [PW-1:0] e_pwr;
    logic          e_mag, e_done;
    logic [1:0]    e_state;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [9:0] kp, input logic st, sp, cl, pk, dr,
                     input int cyc, input logic [3:0] o, t, m, input logic [PW-1:0] p,
                     input logic mg, dn, input logic [1:0] s);
    vec_t v;
    v.r = r; v.kp = kp; v.st = st; v.sp = sp; v.cl = cl; v.pk = pk; v.dr = dr;
    v.cycles = cyc; v.e_ones = o; v.e_tens = t; v.e_mins = m; v.e_pwr = p;
    v.e_mag = mg; v.e_done = dn; v.e_state = s;
    vecs.push_back(v);
  endtask

  // Idle-state key press for one cycle followed by one released cycle
  task automatic key(input logic [9:0] kp, input logic [3:0] o, t, m, input logic [PW-1:0] p);
    add(0, kp, 0, 0, 0, 0, 1, 1, o, t, m, p, 0, 0, 0);
    add(0, '0, 0, 0, 0, 0, 1, 1, o, t, m, p, 0, 0, 0);
  endtask

  // Plain cook cycles: door closed, no requests
  task automatic run(input int cyc, input logic [3:0] o, t, m, input logic [PW-1:0] p,
                     input logic mg, dn, input logic [1:0] s);
    add(0, '0, 0, 0, 0, 0, 1, cyc, o, t, m, p, mg, dn, s);
  endtask

  task automatic check(input string nm, input logic [3:0] o, t, m, input logic [PW-1:0] p,
                       input logic mg, dn, input logic [1:0] s);
    logic [3+4+4+PW+1+1+1:0] act, exp;
    act = {sec_ones, sec_tens, 4'(mins), power, mag_on, done, state};
    exp = {o, t, m, p, mg, dn, s};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got ones=%0d tens=%0d mins=%0d pwr=%0d mag=%b done=%b state=%0d, want ones=%0d tens=%0d mins=%0d pwr=%0d mag=%b done=%b state=%0d",
               nm, sec_ones, sec_tens, mins, power, mag_on, done, state, o, t, m, p, mg, dn, s);
    end
  endtask

  task automatic cmp_int(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  initial begin
    int done_cnt, bad_mag;
    bit seen_done, finished;
    rst = 1'b1; keypad = '0; start = 0; stop = 0; clear = 0; power_key = 0; door_closed = 1;

    // reset state
    add(1, '0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 4, 0, 0, 0);
    // entry shift, dropped top digit, held key, non-one-hot
    key(10'b10, 1, 0, 0, 4);
    key(10'b1000, 3, 1, 0, 4);
    key(10'b1, 0, 3, 1, 4);
    add(0, 10'b100000, 0, 0, 0, 0, 1, 3, 5, 0, 3, 4, 0, 0, 0);
    add(0, 10'b11, 0, 0, 0, 0, 1, 1, 5, 0, 3, 4, 0, 0, 0);
    add(0, '0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 4, 0, 0, 0);
    add(0, '0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 4, 0, 0, 0);
    // 0:12 full power through DONE window
    key(10'b10, 1, 0, 0, 4);
    key(10'b100, 2, 1, 0, 4);
    add(0, '0, 1, 0, 0, 0, 1, 1, 2, 1, 0, 4, 1, 0, 1);
    run(3, 2, 1, 0, 4, 1, 0, 1);
    run(1, 1, 1, 0, 4, 1, 0, 1);
    run(43, 1, 0, 0, 4, 1, 0, 1);
    run(1, 0, 0, 0, 4, 0, 1, 3);
    run(7, 0, 0, 0, 4, 0, 1, 3);
    run(1, 0, 0, 0, 4, 0, 0, 0);
    // 1:00 borrow from minutes, then pause and cancel
    key(10'b10, 1, 0, 0, 4);
    key(10'b1, 0, 1, 0, 4);
    key(10'b1, 0, 0, 1, 4);
    add(0, '0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 4, 1, 0, 1);
    run(4, 9, 5, 0, 4, 1, 0, 1);
    add(0, '0, 0, 1, 0, 0, 1, 1, 9, 5, 0, 4, 0, 0, 2);
    add(0, '0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 4, 0, 0, 0);
    // 0:90 unchecked tens entry
    key(10'b1000000000, 9, 0, 0, 4);
    key(10'b1, 0, 9, 0, 4);
    add(0, '0, 1, 0, 0, 0, 1, 1, 0, 9, 0, 4, 1, 0, 1);
    run(4, 9, 8, 0, 4, 1, 0, 1);
    run(36, 0, 8, 0, 4, 1, 0, 1);
    run(4, 9, 7, 0, 4, 1, 0, 1);
    add(0, '0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 4, 0, 0, 0);
    // power stepping and duty pattern at power 2
    add(0, '0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    run(1, 0, 0, 0, 1, 0, 0, 0);
    add(0, '0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 2, 0, 0, 0);
    run(1, 0, 0, 0, 2, 0, 0, 0);
    key(10'b100000000, 8, 0, 0, 2);
    add(0, '0, 1, 0, 0, 0, 1, 1, 8, 0, 0, 2, 1, 0, 1);
    run(3, 8, 0, 0, 2, 1, 0, 1);
    run(1, 7, 0, 0, 2, 1, 0, 1);
    run(4, 6, 0, 0, 2, 0, 0, 1);
    run(4, 5, 0, 0, 2, 0, 0, 1);
    run(4, 4, 0, 0, 2, 1, 0, 1);
    add(0, '0, 0, 0, 0, 1, 1, 4, 3, 0, 0, 2, 1, 0, 1);
    run(3, 3, 0, 0, 2, 1, 0, 1);
    // door opens on the tick cycle: same-cycle mag drop, tick discarded
    add(0, '0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 2, 0, 0, 1);
    add(0, '0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 2, 0, 0, 2);
    add(0, '0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 2, 0, 0, 2);
    add(0, '0, 1, 0, 0, 0, 1, 1, 3, 0, 0, 2, 1, 0, 1);
    run(4, 2, 0, 0, 2, 0, 0, 1);
    add(0, '0, 0, 1, 0, 0, 1, 1, 2, 0, 0, 2, 0, 0, 2);
    add(0, '0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0);
    // clear + stop on a tick cycle
    key(10'b100000, 5, 0, 0, 2);
    add(0, '0, 1, 0, 0, 0, 1, 1, 5, 0, 0, 2, 1, 0, 1);
    run(3, 5, 0, 0, 2, 1, 0, 1);
    add(0, '0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 4, 0, 0, 0);
    // reset mid-cook
    add(0, '0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    run(1, 0, 0, 0, 1, 0, 0, 0);
    key(10'b10000000, 7, 0, 0, 1);
    add(0, '0, 1, 0, 0, 0, 1, 1, 7, 0, 0, 1, 1, 0, 1);
    run(2, 7, 0, 0, 1, 1, 0, 1);
    add(1, '0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4, 0, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].r; keypad = vecs[i].kp; start = vecs[i].st; stop = vecs[i].sp;
      clear = vecs[i].cl; power_key = vecs[i].pk; door_closed = vecs[i].dr;
      repeat (vecs[i].cycles) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_ones, vecs[i].e_tens, vecs[i].e_mins,
            vecs[i].e_pwr, vecs[i].e_mag, vecs[i].e_done, vecs[i].e_state);
    end

    // 0:03 at full power: done must last exactly 8 cycles, mag only in COOK
    rst = 0; keypad = '0; start = 0; stop = 0; clear = 0; power_key = 0; door_closed = 1;
    keypad = 10'b1000;
    @(posedge clk); #1;
    keypad = '0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cmp_int("seq_cook_entry", int'(state), 1);
    done_cnt = 0; bad_mag = 0; seen_done = 0; finished = 0;
    for (int c = 0; c < 100 && !finished; c++) begin
      @(posedge clk); #1;
      if (mag_on && state != 2'd1) bad_mag++;
      if (done) begin
        done_cnt++;
        seen_done = 1;
      end
      if (seen_done && state == 2'd0) finished = 1;
    end
    cmp_int("seq_finished", int'(finished), 1);
    cmp_int("seq_done_len", done_cnt, 2 * TPS);
    cmp_int("seq_mag_outside_cook", bad_mag, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
